// File: rtl/scheduler_if.sv
// -----------------------------------------------------------------------------
// scheduler_if
// Bus between the channel register bank, the scheduler and the downstream link.
//   r0..r3    channel words presented to the scheduler (DATA_WIDTH each)
//   data_out  registered scheduled word                (DATA_WIDTH)
//   ch_sel    registered index of the channel on data_out (2 bits)
//   valid     registered; 1 = data_out carries a scheduled word
// Modports:
//   master  - the side that supplies the channel words and observes the output
//   slave   - the scheduler itself
// -----------------------------------------------------------------------------
interface scheduler_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] r0;
  logic [DATA_WIDTH-1:0] r1;
  logic [DATA_WIDTH-1:0] r2;
  logic [DATA_WIDTH-1:0] r3;
  logic [DATA_WIDTH-1:0] data_out;
  logic [1:0]            ch_sel;
  logic                  valid;

  modport master (
    output r0, r1, r2, r3,
    input  data_out, ch_sel, valid
  );

  modport slave (
    input  r0, r1, r2, r3,
    output data_out, ch_sel, valid
  );
endinterface

// File: rtl/scheduler.sv
// -----------------------------------------------------------------------------
// scheduler
// Weighted round-robin time-division scheduler. Four channel words are
// serialised onto one registered output bus, one word per clock. Channel i
// receives Wi consecutive slots before the pointer moves on; Wi = 0 disables
// the channel. There is no backpressure.
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous, active-high reset
//   bus   scheduler_if.slave: r0..r3 in, data_out/ch_sel/valid out (registered)
//
// Parameters: DATA_WIDTH, W0..W3 (4-bit slot weights, 0 = channel disabled).
//
// Optional feature macro: SCHED_SKIP_ZERO_EN
//   When defined, a channel whose current word is zero is treated as idle for
//   that cycle and skipped in the same search as disabled channels. When no
//   channel is eligible, valid/data_out/ch_sel go to zero and ptr/cnt hold.
// -----------------------------------------------------------------------------
module scheduler #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [3:0] W0         = 4'd1,
  parameter logic [3:0] W1         = 4'd1,
  parameter logic [3:0] W2         = 4'd1,
  parameter logic [3:0] W3         = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  scheduler_if.slave bus
);

  logic [3:0]            weight_s [4];
  logic [DATA_WIDTH-1:0] word_s   [4];
  logic [3:0]            eligible_s;
  logic [7:0]            eligible_dbl_s;
  logic [3:0]            rot_s;
  logic [1:0]            off_s;
  logic                  found_s;
  logic [1:0]            grant_s;
  logic [3:0]            cnt_base_s;
  logic [3:0]            cnt_next_s;
  logic                  last_slot_s;

  logic [1:0]            ptr_r;
  logic [3:0]            cnt_r;

  assign weight_s[0] = W0;
  assign weight_s[1] = W1;
  assign weight_s[2] = W2;
  assign weight_s[3] = W3;

  assign word_s[0] = bus.r0;
  assign word_s[1] = bus.r1;
  assign word_s[2] = bus.r2;
  assign word_s[3] = bus.r3;

  // Per-channel eligibility for a slot this cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
`ifdef SCHED_SKIP_ZERO_EN
      eligible_s[i] = (weight_s[i] != 4'd0) && (word_s[i] != {DATA_WIDTH{1'b0}});
`else
      eligible_s[i] = (weight_s[i] != 4'd0);
`endif
    end
  end

  // Rotate eligibility so bit k stands for channel (ptr + k) mod 4; the
  // lowest set bit is then the first eligible channel in round-robin order.
  assign eligible_dbl_s = {eligible_s, eligible_s};
  assign rot_s          = eligible_dbl_s[ptr_r +: 4];

  // Priority-encode the rotated eligibility into an offset from ptr.
  always_comb begin
    found_s = 1'b1;
    off_s   = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        found_s = 1'b0;
        off_s   = 2'd0;
      end
    endcase
  end

  assign grant_s = ptr_r + off_s;

  // Slots already used only carry over when the grant stays on ptr; a jump
  // to another channel starts that channel's slot count afresh.
  assign cnt_base_s  = (off_s == 2'd0) ? cnt_r : 4'd0;
  assign cnt_next_s  = cnt_base_s + 4'd1;
  assign last_slot_s = (cnt_next_s == weight_s[grant_s]);

  // Output registers and round-robin pointer / slot counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data_out <= {DATA_WIDTH{1'b0}};
      bus.ch_sel   <= 2'd0;
      bus.valid    <= 1'b0;
      ptr_r        <= 2'd0;
      cnt_r        <= 4'd0;
    end else if (found_s) begin
      bus.data_out <= word_s[grant_s];
      bus.ch_sel   <= grant_s;
      bus.valid    <= 1'b1;
      if (last_slot_s) begin
        ptr_r <= grant_s + 2'd1;
        cnt_r <= 4'd0;
      end else begin
        ptr_r <= grant_s;
        cnt_r <= cnt_next_s;
      end
    end else begin
      bus.data_out <= {DATA_WIDTH{1'b0}};
      bus.ch_sel   <= 2'd0;
      bus.valid    <= 1'b0;
      ptr_r        <= ptr_r;
      cnt_r        <= cnt_r;
    end
  end

endmodule

// File: tb/tb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_scheduler
// Self-checking bench for scheduler. Three instances share clk/rst:
//   u_def  default weights 1,1,1,1
//   u_w    weights 3,1,0,1
//   u_z    all weights 0
// The reference model expands each weight set into its repeating grant list
// (channel i listed Wi times, in channel order) and indexes it by the number
// of non-reset edges since the last reset. Expected data is the channel word
// that was on the inputs at that edge.
// -----------------------------------------------------------------------------
module tb_scheduler;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  scheduler_if #(.DATA_WIDTH(DW)) bus_def ();
  scheduler_if #(.DATA_WIDTH(DW)) bus_w ();
  scheduler_if #(.DATA_WIDTH(DW)) bus_z ();

  scheduler #(.DATA_WIDTH(DW)) u_def (
    .clk (clk),
    .rst (rst),
    .bus (bus_def)
  );

  scheduler #(.DATA_WIDTH(DW), .W0(4'd3), .W1(4'd1), .W2(4'd0), .W3(4'd1)) u_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  scheduler #(.DATA_WIDTH(DW), .W0(4'd0), .W1(4'd0), .W2(4'd0), .W3(4'd0)) u_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;

  // Grant lists: default weights -> 0,1,2,3 ; weights 3,1,0,1 -> 0,0,0,1,3
  int def_list [4] = '{0, 1, 2, 3};
  int w_list   [5] = '{0, 0, 0, 1, 3};

  logic [DW-1:0] cur [4];

  logic [DW-1:0] exp_data_def, exp_data_w;
  logic [1:0]    exp_ch_def, exp_ch_w;
  logic          exp_valid_def, exp_valid_w;

  // Drive the same channel words into every instance.
  task automatic set_r(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
    cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d;
    bus_def.r0 = a; bus_def.r1 = b; bus_def.r2 = c; bus_def.r3 = d;
    bus_w.r0   = a; bus_w.r1   = b; bus_w.r2   = c; bus_w.r3   = d;
    bus_z.r0   = a; bus_z.r1   = b; bus_z.r2   = c; bus_z.r3   = d;
  endtask

  // Advance one clock and update the model's expected outputs for that edge.
  task automatic tick();
    logic [DW-1:0] snap [4];
    logic          rst_snap;
    int            ch;
    snap     = cur;
    rst_snap = rst;
    @(posedge clk);
    #1;
    if (rst_snap) begin
      exp_valid_def = 1'b0; exp_data_def = 16'h0000; exp_ch_def = 2'd0;
      exp_valid_w   = 1'b0; exp_data_w   = 16'h0000; exp_ch_w   = 2'd0;
      n_edge = 0;
    end else begin
      ch = def_list[n_edge % 4];
      exp_valid_def = 1'b1; exp_data_def = snap[ch]; exp_ch_def = 2'(ch);
      ch = w_list[n_edge % 5];
      exp_valid_w   = 1'b1; exp_data_w   = snap[ch]; exp_ch_w   = 2'(ch);
      n_edge++;
    end
  endtask

  task automatic test_reset();
    set_r(16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (bus_def.valid !== 1'b0 || bus_def.data_out !== 16'h0000 || bus_def.ch_sel !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_def cycle %0d: got data=%h ch=%0d valid=%b, expected data=0000 ch=0 valid=0",
                 i, bus_def.data_out, bus_def.ch_sel, bus_def.valid);
      end
      n_checks++;
      if (bus_w.valid !== 1'b0 || bus_w.data_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_w cycle %0d: got data=%h valid=%b, expected data=0000 valid=0",
                 i, bus_w.data_out, bus_w.valid);
      end
    end
  endtask

  task automatic test_default_seq();
    set_r(16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (bus_def.data_out !== exp_data_def || bus_def.ch_sel !== exp_ch_def || bus_def.valid !== 1'b1) begin
        n_fail++;
        $display("FAIL default_seq cycle %0d: got data=%h ch=%0d valid=%b, expected data=%h ch=%0d valid=1",
                 i, bus_def.data_out, bus_def.ch_sel, bus_def.valid, exp_data_def, exp_ch_def);
      end
    end
  endtask

  task automatic test_weighted();
    for (int i = 0; i < 15; i++) begin
      tick();
      n_checks++;
      if (bus_w.data_out !== exp_data_w || bus_w.ch_sel !== exp_ch_w || bus_w.valid !== exp_valid_w) begin
        n_fail++;
        $display("FAIL weighted cycle %0d: got data=%h ch=%0d valid=%b, expected data=%h ch=%0d valid=%b",
                 i, bus_w.data_out, bus_w.ch_sel, bus_w.valid, exp_data_w, exp_ch_w, exp_valid_w);
      end
      n_checks++;
      if (bus_w.ch_sel === 2'd2 || bus_w.data_out === 16'hcccc) begin
        n_fail++;
        $display("FAIL weighted_disabled cycle %0d: got ch=%0d data=%h, expected channel 2 never granted",
                 i, bus_w.ch_sel, bus_w.data_out);
      end
      n_checks++;
      if (bus_z.valid !== 1'b0 || bus_z.data_out !== 16'h0000 || bus_z.ch_sel !== 2'd0) begin
        n_fail++;
        $display("FAIL all_zero_weights cycle %0d: got data=%h ch=%0d valid=%b, expected 0000/0/0",
                 i, bus_z.data_out, bus_z.ch_sel, bus_z.valid);
      end
    end
  endtask

  task automatic test_latency();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_r(16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd);
    tick();
    n_checks++;
    if (bus_def.data_out !== 16'haaaa || bus_def.ch_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL latency_r0: got data=%h ch=%0d, expected data=aaaa ch=0",
               bus_def.data_out, bus_def.ch_sel);
    end
    set_r(16'haaaa, 16'h1234, 16'hcccc, 16'hdddd);
    tick();
    n_checks++;
    if (bus_def.data_out !== 16'h1234 || bus_def.ch_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL latency_r1: got data=%h ch=%0d, expected data=1234 ch=1",
               bus_def.data_out, bus_def.ch_sel);
    end
    n_checks++;
    if (bus_w.data_out !== exp_data_w || bus_w.ch_sel !== exp_ch_w) begin
      n_fail++;
      $display("FAIL latency_w: got data=%h ch=%0d, expected data=%h ch=%0d",
               bus_w.data_out, bus_w.ch_sel, exp_data_w, exp_ch_w);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_r(16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd);
    tick(); tick(); tick();
    n_checks++;
    if (bus_def.ch_sel !== 2'd2 || bus_def.data_out !== 16'hcccc) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got data=%h ch=%0d, expected data=cccc ch=2",
               bus_def.data_out, bus_def.ch_sel);
    end
    // Raise reset between edges: outputs must hold until the next edge.
    rst = 1'b1;
    #3;
    n_checks++;
    if (bus_def.data_out !== 16'hcccc || bus_def.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_sync: got data=%h valid=%b, expected data=cccc valid=1 before edge",
               bus_def.data_out, bus_def.valid);
    end
    tick();
    n_checks++;
    if (bus_def.data_out !== 16'h0000 || bus_def.valid !== 1'b0 || bus_def.ch_sel !== 2'd0 ||
        bus_w.valid !== 1'b0 || bus_w.data_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got def data=%h valid=%b w valid=%b, expected zeros",
               bus_def.data_out, bus_def.valid, bus_w.valid);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus_def.data_out !== 16'haaaa || bus_def.ch_sel !== 2'd0 || bus_def.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got data=%h ch=%0d valid=%b, expected data=aaaa ch=0 valid=1",
               bus_def.data_out, bus_def.ch_sel, bus_def.valid);
    end
    n_checks++;
    if (bus_w.data_out !== 16'haaaa || bus_w.ch_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_restart_w: got data=%h ch=%0d, expected data=aaaa ch=0",
               bus_w.data_out, bus_w.ch_sel);
    end
  endtask

  task automatic test_random();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 300; i++) begin
      set_r(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)),
            16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)));
      rst = ($urandom_range(0, 29) == 0);
      tick();
      n_checks++;
      if (bus_def.data_out !== exp_data_def || bus_def.ch_sel !== exp_ch_def || bus_def.valid !== exp_valid_def) begin
        n_fail++;
        $display("FAIL random_def cycle %0d: got data=%h ch=%0d valid=%b, expected data=%h ch=%0d valid=%b",
                 i, bus_def.data_out, bus_def.ch_sel, bus_def.valid, exp_data_def, exp_ch_def, exp_valid_def);
      end
      n_checks++;
      if (bus_w.data_out !== exp_data_w || bus_w.ch_sel !== exp_ch_w || bus_w.valid !== exp_valid_w) begin
        n_fail++;
        $display("FAIL random_w cycle %0d: got data=%h ch=%0d valid=%b, expected data=%h ch=%0d valid=%b",
                 i, bus_w.data_out, bus_w.ch_sel, bus_w.valid, exp_data_w, exp_ch_w, exp_valid_w);
      end
      n_checks++;
      if (bus_z.valid !== 1'b0 || bus_z.data_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL random_zero_weights cycle %0d: got data=%h valid=%b, expected 0000/0",
                 i, bus_z.data_out, bus_z.valid);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_word();
`ifdef SCHED_SKIP_ZERO_EN
    int skip_list [3] = '{0, 2, 3};
    int ch;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_r(16'haaaa, 16'h0000, 16'hcccc, 16'hdddd);
    for (int i = 0; i < 9; i++) begin
      tick();
`ifdef SCHED_SKIP_ZERO_EN
      ch = skip_list[i % 3];
      n_checks++;
      if (bus_def.data_out !== cur[ch] || bus_def.ch_sel !== 2'(ch) || bus_def.valid !== 1'b1) begin
        n_fail++;
        $display("FAIL skip_zero cycle %0d: got data=%h ch=%0d valid=%b, expected data=%h ch=%0d valid=1",
                 i, bus_def.data_out, bus_def.ch_sel, bus_def.valid, cur[ch], ch);
      end
`else
      n_checks++;
      if (bus_def.data_out !== exp_data_def || bus_def.ch_sel !== exp_ch_def || bus_def.valid !== 1'b1) begin
        n_fail++;
        $display("FAIL zero_word cycle %0d: got data=%h ch=%0d valid=%b, expected data=%h ch=%0d valid=1",
                 i, bus_def.data_out, bus_def.ch_sel, bus_def.valid, exp_data_def, exp_ch_def);
      end
`endif
    end
    set_r(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
`ifdef SCHED_SKIP_ZERO_EN
      if (bus_def.valid !== 1'b0 || bus_def.data_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL skip_all_zero cycle %0d: got data=%h valid=%b, expected data=0000 valid=0",
                 i, bus_def.data_out, bus_def.valid);
      end
`else
      if (bus_def.valid !== 1'b1 || bus_def.data_out !== 16'h0000 || bus_def.ch_sel !== exp_ch_def) begin
        n_fail++;
        $display("FAIL all_zero_words cycle %0d: got data=%h ch=%0d valid=%b, expected data=0000 ch=%0d valid=1",
                 i, bus_def.data_out, bus_def.ch_sel, bus_def.valid, exp_ch_def);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_default_seq();
    test_weighted();
    test_latency();
    test_reset_mid();
    test_random();
    test_zero_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
